drv_err_bank: RTL
=================

DRV_ERR_BANK -- requirements
Module: drv_err_bank

Interface
REQ-001 SHALL have parameter NDRV, default 8, number of drives (1..8).
REQ-002 SHALL have parameter WIDTH, default 16, error register width.
REQ-003 SHALL have parameter RMR_BIT, default 2, bit index of Register Modification Refused.
REQ-004 SHALL have parameter CNT_W, default 4, error-event counter width.
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clrALL  in  1  controller clear, all drives
- clrDRV  in  NDRV  per-drive clear (drive-clear function)
- drvSEL  in  3  selected drive for bus access
- wrDATA  in  WIDTH  bus write data
- errWRITE  in  1  write error register of drvSEL
- anyWRITE  in  1  write to any register of drvSEL
- ataWRITE  in  1  attention write, write-1-to-clear, mask wrDATA[NDRV-1:0]
- drvRDY  in  NDRV  drive ready
- setERR  in  NDRV*WIDTH  hardware error set strobes, drive i in slice i
- rdDATA  out  WIDTH  error register of drvSEL
- rdFIRST  out  8  {valid, 3'b0, first-bit index[3:0]} of drvSEL
- rdCNT  out  CNT_W  event count of drvSEL
- errSUM  out  NDRV  per-drive OR of error register
- ATA  out  NDRV  per-drive attention

Function
REQ-006 SHALL hold one WIDTH-bit error register E[i], counter C[i], first-error index F[i] and valid V[i] per drive.
REQ-007 SHALL apply per-drive priority each clk: clrALL or clrDRV[i] > bus write > hardware set.
REQ-008 Clear SHALL zero E[i], C[i], F[i] and V[i], and discard same-cycle setERR for that drive; ATA[i] is unaffected.
REQ-009 errWRITE with drvSEL=i and drvRDY[i]=1 SHALL load E[i] <= wrDATA | setERR[i].
REQ-010 anyWRITE or errWRITE with drvSEL=i and drvRDY[i]=0 SHALL leave E[i] unchanged except E[i][RMR_BIT] <= 1, OR'd with setERR[i].
REQ-011 Absent clear or write, E[i] SHALL update as E[i] | setERR[i], so bits stay sticky.
REQ-012 Define new[i] = next E[i] & ~E[i], per cycle.
REQ-013 C[i] SHALL increment by 1 when new[i] != 0, and saturate at 2^CNT_W-1.
REQ-014 When V[i]=0 and new[i] != 0, F[i] SHALL capture the lowest set index of new[i] and V[i] <= 1; F[i] SHALL then hold until clear.
REQ-015 A bus write that zeroes E[i] SHALL clear V[i] but not C[i].
REQ-016 errSUM[i] SHALL be the registered OR of E[i], with no added latency beyond E.
REQ-017 ATA[i] SHALL set on the cycle after errSUM[i] goes 0->1 (edge of E[i] nonzero).
REQ-018 ataWRITE SHALL clear ATA[i] where wrDATA[i]=1; a simultaneous set SHALL win over the clear.
REQ-019 Read outputs SHALL be combinational muxes of drvSEL; a drvSEL >= NDRV SHALL read zero.
REQ-020 Writes with drvSEL >= NDRV SHALL be ignored.
REQ-021 Drives SHALL be fully independent; setERR on several drives in one cycle SHALL update all of them.

Reset
REQ-022 rst SHALL asynchronously force all E, C, F, V, ATA to 0, so every output reads 0.
REQ-023 rst asserted mid-operation SHALL override all same-cycle writes and sets.

Verification
REQ-024 setERR drive 2 = 0x0040, then 0x0041 -> E[2]=0x0041, C=2, F=6 valid, ATA[2]=1 one cycle after first set.
REQ-025 drvRDY[3]=0, errWRITE drv 3 data 0x8000 -> E[3]=0x0004 (RMR), data discarded, C=1.
REQ-026 clrDRV[2] with setERR drive 2 = 0x0001 in the same cycle -> E[2]=0, C=0, V=0, ATA[2] still 1.
REQ-027 ataWRITE mask 0x04 in the same cycle drive 2 goes 0->nonzero -> ATA[2] remains 1.
REQ-028 20 distinct new-bit events on drive 0 with CNT_W=4 -> rdCNT=15, saturated.
REQ-029 rst pulse during errWRITE 0xFFFF -> all registers 0, rdDATA=0.

Source files
------------

// File: rtl/drv_err_bank.sv
// drv_err_bank
//   Per-drive error register bank for a multi-drive disk controller. Each
//   drive keeps a sticky WIDTH-bit error register, a saturating count of
//   error events (cycles that set at least one new bit), the index of the
//   first error bit seen since the last clear, and an attention flag raised
//   when the drive's error summary goes from clean to dirty.
//
// Ports
//   clk, rst   clock; asynchronous active-high reset
//   clrALL     clear every drive's error state
//   clrDRV     per-drive clear
//   drvSEL     drive addressed by the bus (reads and writes)
//   wrDATA     bus write data (also the attention clear mask)
//   errWRITE   write the error register of drvSEL
//   anyWRITE   write to any register of drvSEL
//   ataWRITE   write-1-to-clear of ATA using wrDATA[NDRV-1:0]
//   drvRDY     drive ready; writes to a busy drive are refused
//   setERR     hardware error set strobes, drive i in slice i
//   rdDATA     error register of drvSEL
//   rdFIRST    {valid, 3'b0, first-bit index} of drvSEL
//   rdCNT      event count of drvSEL
//   errSUM     per-drive OR of the error register
//   ATA        per-drive attention

module drv_err_bank #(
  parameter int NDRV    = 8,
  parameter int WIDTH   = 16,
  parameter int RMR_BIT = 2,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clrALL,
  input  logic [NDRV-1:0]       clrDRV,
  input  logic [2:0]            drvSEL,
  input  logic [WIDTH-1:0]      wrDATA,
  input  logic                  errWRITE,
  input  logic                  anyWRITE,
  input  logic                  ataWRITE,
  input  logic [NDRV-1:0]       drvRDY,
  input  logic [NDRV*WIDTH-1:0] setERR,
  output logic [WIDTH-1:0]      rdDATA,
  output logic [7:0]            rdFIRST,
  output logic [CNT_W-1:0]      rdCNT,
  output logic [NDRV-1:0]       errSUM,
  output logic [NDRV-1:0]       ATA
);

  logic [NDRV-1:0][WIDTH-1:0] err_q, err_d;
  logic [NDRV-1:0][WIDTH-1:0] new_bits;
  logic [NDRV-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NDRV-1:0][3:0]       first_q, first_d;
  logic [NDRV-1:0]            vld_q, vld_d;
  logic [NDRV-1:0]            ata_q, ata_d;

  // Lowest set bit index; a zero vector yields 0 but is never used that way.
  function automatic logic [3:0] lowest_idx(input logic [WIDTH-1:0] v);
    logic [3:0] r;
    r = '0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      if (v[b]) r = 4'(b);
    end
    return r;
  endfunction

  // Next-state for every drive. Priority is clear > bus write > hardware
  // set. A write to a busy drive is refused: the data is dropped and the
  // Register Modification Refused bit is raised instead.
  always_comb begin
    err_d    = err_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    vld_d    = vld_q;
    ata_d    = ata_q;
    new_bits = '0;
    for (int i = 0; i < NDRV; i++) begin
      if (clrALL || clrDRV[i]) begin
        err_d[i]   = '0;
        cnt_d[i]   = '0;
        first_d[i] = '0;
        vld_d[i]   = 1'b0;
      end else begin
        if (errWRITE && drvSEL == 3'(i) && drvRDY[i]) begin
          err_d[i] = wrDATA | setERR[i*WIDTH +: WIDTH];
        end else if ((errWRITE || anyWRITE) && drvSEL == 3'(i) && !drvRDY[i]) begin
          err_d[i] = err_q[i] | setERR[i*WIDTH +: WIDTH];
          err_d[i][RMR_BIT] = 1'b1;
        end else begin
          err_d[i] = err_q[i] | setERR[i*WIDTH +: WIDTH];
        end

        new_bits[i] = err_d[i] & ~err_q[i];

        if (new_bits[i] != '0) begin
          if (cnt_q[i] != {CNT_W{1'b1}}) cnt_d[i] = cnt_q[i] + 1'b1;
          if (!vld_q[i]) begin
            first_d[i] = lowest_idx(new_bits[i]);
            vld_d[i]   = 1'b1;
          end
        end

        // A write that wipes the register also forgets the first-error
        // capture, so the next error is reported afresh; the count is kept.
        if (err_d[i] == '0) begin
          first_d[i] = '0;
          vld_d[i]   = 1'b0;
        end
      end

      // Attention: the clear mask applies first, so a clean-to-dirty edge in
      // the same cycle wins.
      if (ataWRITE && wrDATA[i]) ata_d[i] = 1'b0;
      if ((err_d[i] != '0) && (err_q[i] == '0)) ata_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      vld_q   <= '0;
      ata_q   <= '0;
    end else begin
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      vld_q   <= vld_d;
      ata_q   <= ata_d;
    end
  end

  // Read mux; a drive number beyond the bank matches nothing and reads 0.
  always_comb begin
    rdDATA  = '0;
    rdFIRST = '0;
    rdCNT   = '0;
    for (int i = 0; i < NDRV; i++) begin
      if (drvSEL == 3'(i)) begin
        rdDATA  = err_q[i];
        rdFIRST = {vld_q[i], 3'b000, first_q[i]};
        rdCNT   = cnt_q[i];
      end
    end
  end

  always_comb begin
    errSUM = '0;
    for (int i = 0; i < NDRV; i++) errSUM[i] = |err_q[i];
  end

  assign ATA = ata_q;

endmodule
